// File: rtl/sha3_pkg.sv
// Shared SHA-3 types: state array, digest mode encoding, digest length helper.
// Types:     state_t (Keccak state indexed [x][y]), sha3_mode_e (224/256/384/512).
// Constants: MAX_DIGEST_BITS; function digest_bits() maps a mode to its length.
package sha3_pkg;

  typedef logic [0:4][0:4][63:0] state_t;

  typedef enum logic [1:0] {
    SHA3_224 = 2'd0,
    SHA3_256 = 2'd1,
    SHA3_384 = 2'd2,
    SHA3_512 = 2'd3
  } sha3_mode_e;

  localparam int MAX_DIGEST_BITS = 512;

  function automatic int unsigned digest_bits(sha3_mode_e m);
    case (m)
      SHA3_224: return 224;
      SHA3_256: return 256;
      SHA3_384: return 384;
      default:  return 512;
    endcase
  endfunction

endpackage

// File: rtl/axis_digest_tx.sv
// Streams a truncated Keccak digest out as an AXI4-Stream master, beat 0 first.
// Latency: start at edge k -> beat 0 valid in cycle k+1; one beat per cycle while ready.
// Backpressure: M_TREADY low holds every output; start is ignored while busy.
// Ports: ACLK/ARESET (sync, active-high); start/mode/state_in capture a final state;
//        busy/done status; M_TVALID/M_TREADY/M_TDATA/M_TLAST/M_TUSER stream (TUSER = mode).
// Option: define AXIS_DIGEST_TX_BYTESWAP_EN to reverse byte order within each beat.
module axis_digest_tx
  import sha3_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                   ACLK,
  input  logic                   ARESET,
  input  logic                   start,
  input  logic [1:0]             mode,
  input  logic [0:4][0:4][63:0]  state_in,
  output logic                   busy,
  output logic                   done,
  output logic                   M_TVALID,
  input  logic                   M_TREADY,
  output logic [DATA_WIDTH-1:0]  M_TDATA,
  output logic                   M_TLAST,
  output logic [1:0]             M_TUSER
);

  // Every legal width divides 224, so each digest length is a whole number of beats.
  if (DATA_WIDTH != 8 && DATA_WIDTH != 16 && DATA_WIDTH != 32) begin : g_bad_width
    $error("axis_digest_tx: DATA_WIDTH must be 8, 16 or 32");
  end

  localparam int BEATS_MAX = MAX_DIGEST_BITS / DATA_WIDTH;
  localparam int CNT_W     = $clog2(BEATS_MAX);
  localparam int NBYTES    = DATA_WIDTH / 8;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_SEND = 1'b1;

  logic                       state_q, state_d;
  logic [MAX_DIGEST_BITS-1:0] sreg_q, sreg_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [1:0]                 mode_q, mode_d;
  logic                       done_q, done_d;

  logic [MAX_DIGEST_BITS-1:0] flat;
  logic [CNT_W-1:0]           last_idx;
  logic                       hs;

  // Lane L = x + 5y sits at flat bits [64L+63:64L]; only the first 8 lanes can
  // reach the longest digest.
  for (genvar l = 0; l < MAX_DIGEST_BITS / 64; l++) begin : g_flat
    assign flat[64*l +: 64] = state_in[l % 5][l / 5];
  end

  always_comb begin
    last_idx = CNT_W'(digest_bits(sha3_mode_e'(mode_q)) / DATA_WIDTH - 1);
  end

  assign M_TVALID = (state_q == ST_SEND);
  assign busy     = M_TVALID;
  assign hs       = M_TVALID && M_TREADY;
  assign M_TLAST  = M_TVALID && (cnt_q == last_idx);
  assign M_TUSER  = mode_q;
  assign done     = done_q;

`ifdef AXIS_DIGEST_TX_BYTESWAP_EN
  // Byte 0 of the beat lands at the MSB end; beat order is untouched.
  for (genvar b = 0; b < NBYTES; b++) begin : g_bswap
    assign M_TDATA[8*(NBYTES-1-b) +: 8] = sreg_q[8*b +: 8];
  end
`else
  assign M_TDATA = sreg_q[DATA_WIDTH-1:0];
`endif

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SEND;
          sreg_d  = flat;
          cnt_d   = '0;
          mode_d  = mode;
        end
      end
      default: begin
        // start is not looked at here, so a pulse during the final handshake is dropped.
        if (hs) begin
          sreg_d = sreg_q >> DATA_WIDTH;
          cnt_d  = cnt_q + CNT_W'(1);
          if (M_TLAST) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q <= ST_IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
      mode_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      done_q  <= done_d;
    end
  end

endmodule
